// File: rtl/fpu_add_subt_sequencer_if.sv
// Handshake and datapath-control bundle between the add/sub sequencer and its
// requester/datapath. The master side drives requests and datapath status; the
// slave side (the sequencer) drives strobes, status and flags.
interface fpu_add_subt_sequencer_if;
    // Requester handshake
    logic beg_op;
    logic ack_op;
    // Datapath status
    logic zero_flag_in;
    logic norm_done_in;
    logic round_ovf_in;
    logic overflow_in;
    logic underflow_in;
    // Datapath strobes
    logic load_opnd;
    logic load_sign;
    logic load_exp;
    logic shift_align;
    logic load_add;
    logic shift_norm;
    logic load_round;
    logic shift_adj;
    // Status and result flags
    logic busy;
    logic ready;
    logic zero_res;
    logic ovf_flag;
    logic unf_flag;

    modport master (
        output beg_op, ack_op, zero_flag_in, norm_done_in, round_ovf_in, overflow_in,
               underflow_in,
        input  load_opnd, load_sign, load_exp, shift_align, load_add, shift_norm, load_round,
               shift_adj, busy, ready, zero_res, ovf_flag, unf_flag
    );

    modport slave (
        input  beg_op, ack_op, zero_flag_in, norm_done_in, round_ovf_in, overflow_in,
               underflow_in,
        output load_opnd, load_sign, load_exp, shift_align, load_add, shift_norm, load_round,
               shift_adj, busy, ready, zero_res, ovf_flag, unf_flag
    );
endinterface

// File: rtl/fpu_add_subt_sequencer.sv
// Control FSM for the floating-point add/subtract datapath. Walks the datapath
// through load, sign, exponent compare, align, add, normalize, round and adjust,
// issuing one-cycle strobes, and hands the result off with a ready/ack handshake.
module fpu_add_subt_sequencer #(
    parameter int unsigned SW = 23,
    parameter int unsigned CW = 5
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    fpu_add_subt_sequencer_if.slave     bus_io
);

    localparam int unsigned   NormMax  = SW + 2;
    localparam logic [CW-1:0] NormMaxC = CW'(NormMax);

    typedef enum logic [3:0] {
        StIdle, StLoad, StSign, StExp, StAlign, StAdd, StNorm, StRound, StAdj, StDone
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          zero_q, zero_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          norm_room;

    // Shift budget left; the counter stops at NormMax so it can never wrap.
    assign norm_room = (cnt_q < NormMaxC);

    // State, normalization counter and latched flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Next-state, counter and flag update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.beg_op) begin
                    state_d = StLoad;
                    zero_d  = 1'b0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                end
            end
            StLoad:  state_d = StSign;
            StSign:  state_d = StExp;
            StExp: begin
                // Exact cancellation: skip the datapath and force +0.
                if (bus_io.zero_flag_in) begin
                    state_d = StDone;
                    zero_d  = 1'b1;
                end else begin
                    state_d = StAlign;
                end
            end
            StAlign: state_d = StAdd;
            StAdd: begin
                state_d = StNorm;
                cnt_d   = '0;
            end
            StNorm: begin
                if (bus_io.norm_done_in) begin
                    state_d = StRound;
                end else if (norm_room) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    // No leading one found within the mantissa: result is zero.
                    state_d = StDone;
                    zero_d  = 1'b1;
                end
            end
            StRound: begin
                ovf_d   = bus_io.overflow_in;
                unf_d   = bus_io.underflow_in;
                state_d = bus_io.round_ovf_in ? StAdj : StDone;
            end
            StAdj:   state_d = StDone;
            StDone: begin
                if (bus_io.ack_op) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus_io.load_opnd   = (state_q == StLoad);
    assign bus_io.load_sign   = (state_q == StSign);
    assign bus_io.load_exp    = (state_q == StExp);
    assign bus_io.shift_align = (state_q == StAlign);
    assign bus_io.load_add    = (state_q == StAdd);
    assign bus_io.shift_norm  = (state_q == StNorm) & ~bus_io.norm_done_in & norm_room;
    assign bus_io.load_round  = (state_q == StRound);
    assign bus_io.shift_adj   = (state_q == StAdj);
    assign bus_io.busy        = (state_q != StIdle) & (state_q != StDone);
    assign bus_io.ready       = (state_q == StDone);
    assign bus_io.zero_res    = zero_q;
    assign bus_io.ovf_flag    = ovf_q;
    assign bus_io.unf_flag    = unf_q;

endmodule

// File: tb/tb_fpu_add_subt_sequencer.sv
// Directed bench for fpu_add_subt_sequencer. Cycle c is counted from the edge
// that accepts beg_op (c=1 is LOAD); outputs are sampled on the falling edge.
module tb_fpu_add_subt_sequencer;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    fpu_add_subt_sequencer_if bus ();

    fpu_add_subt_sequencer #(
        .SW (23),
        .CW (5)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {load_opnd, load_sign, load_exp, shift_align, load_add, shift_norm,
    //  load_round, shift_adj, busy, ready, zero_res, ovf_flag, unf_flag}
    function automatic logic [12:0] dut_vec();
        return {bus.load_opnd, bus.load_sign, bus.load_exp, bus.shift_align, bus.load_add,
                bus.shift_norm, bus.load_round, bus.shift_adj, bus.busy, bus.ready,
                bus.zero_res, bus.ovf_flag, bus.unf_flag};
    endfunction

    // Expected outputs in cycle c, from the documented schedule.
    function automatic logic [12:0] exp_vec(input int c, input int nlow, input bit zf,
                                            input bit rovf, input bit ovf, input bit unf);
        logic [12:0] v;
        bit          lim;
        int          nshift;
        int          norm_end;
        int          done_c;
        v        = '0;
        lim      = (nlow >= 25);
        nshift   = lim ? 25 : nlow;
        norm_end = lim ? 31 : 6 + nlow;
        done_c   = zf ? 4 : (lim ? 32 : 8 + nlow + int'(rovf));
        if (c >= done_c) begin
            v[3] = 1'b1;
            v[2] = zf || lim;
            if (!zf && !lim) begin
                v[1] = ovf;
                v[0] = unf;
            end
        end else begin
            v[4] = 1'b1;
            if (c == 1)      v[12] = 1'b1;
            else if (c == 2) v[11] = 1'b1;
            else if (c == 3) v[10] = 1'b1;
            else if (c == 4) v[9]  = 1'b1;
            else if (c == 5) v[8]  = 1'b1;
            else if (c >= 6 && c <= norm_end) v[7] = (c < 6 + nshift);
            else if (c == norm_end + 1) v[6] = 1'b1;
            else if (c == norm_end + 2) begin
                v[5] = 1'b1;
                v[1] = ovf;
                v[0] = unf;
            end
        end
        return v;
    endfunction

    // Runs one operation from IDLE, checking every cycle, then acks and checks IDLE.
    // Datapath status inputs carry the opposite value outside their valid state.
    task automatic run_op(input string name, input int nlow, input bit zf, input bit rovf,
                          input bit ovf, input bit unf, input bit noise, input int hold,
                          output int ready_cyc, output int shifts);
        int          done_c;
        logic [12:0] got;
        logic [12:0] want;
        done_c    = zf ? 4 : (nlow >= 25 ? 32 : 8 + nlow + int'(rovf));
        ready_cyc = -1;
        shifts    = 0;
        bus.beg_op = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= done_c + hold; c++) begin
            bus.zero_flag_in = (c == 3) ? zf : ~zf;
            bus.norm_done_in = (c >= 6 + nlow);
            bus.round_ovf_in = (c == 7 + nlow) ? rovf : ~rovf;
            bus.overflow_in  = (c == 7 + nlow) ? ovf : ~ovf;
            bus.underflow_in = (c == 7 + nlow) ? unf : ~unf;
            bus.beg_op       = noise && (c < done_c);
            bus.ack_op       = (c == done_c + hold) || (noise && c >= 2 && c < done_c);
            @(negedge clk);
            got  = dut_vec();
            want = exp_vec(c, nlow, zf, rovf, ovf, unf);
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s cycle %0d: outputs %b, required %b", name, c, got, want);
            end
            if (got[3] === 1'b1 && ready_cyc < 0) ready_cyc = c;
            if (got[7] === 1'b1) shifts++;
            @(posedge clk);
            #1;
        end
        bus.ack_op = 1'b0;
        bus.beg_op = 1'b0;
        @(negedge clk);
        got = dut_vec();
        n_checks++;
        if (got[12:3] !== 10'b0) begin
            n_fail++;
            $display("FAIL %s idle after ack: strobes/busy/ready %b, required 0", name, got[12:3]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        bus.beg_op       = 1'b0;
        bus.ack_op       = 1'b0;
        bus.zero_flag_in = 1'b0;
        bus.norm_done_in = 1'b0;
        bus.round_ovf_in = 1'b0;
        bus.overflow_in  = 1'b0;
        bus.underflow_in = 1'b0;
        #3;
        n_checks++;
        if (dut_vec() !== 13'b0) begin
            n_fail++;
            $display("FAIL reset_async: outputs %b, required 0", dut_vec());
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dut_vec() !== 13'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: outputs %b, required 0", dut_vec());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_normal_add();
        int rc, sh;
        run_op("normal_add", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, rc, sh);
        n_checks++;
        if (rc !== 8 || sh !== 0) begin
            n_fail++;
            $display("FAIL normal_add_latency: ready cycle %0d shifts %0d, required 8 and 0", rc, sh);
        end
    endtask

    task automatic test_cancel();
        int rc, sh;
        run_op("cancel", 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, rc, sh);
        n_checks++;
        if (rc !== 13 || sh !== 5) begin
            n_fail++;
            $display("FAIL cancel_latency: ready cycle %0d shifts %0d, required 13 and 5", rc, sh);
        end
    endtask

    task automatic test_zero_shortcut();
        int rc, sh;
        run_op("zero_shortcut", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, rc, sh);
        n_checks++;
        if (rc !== 4 || sh !== 0) begin
            n_fail++;
            $display("FAIL zero_shortcut_latency: ready cycle %0d shifts %0d, required 4 and 0",
                     rc, sh);
        end
    endtask

    task automatic test_norm_limit();
        int rc, sh;
        run_op("norm_limit", 99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, rc, sh);
        n_checks++;
        if (rc !== 32 || sh !== 25) begin
            n_fail++;
            $display("FAIL norm_limit_latency: ready cycle %0d shifts %0d, required 32 and 25",
                     rc, sh);
        end
    endtask

    task automatic test_round_carry();
        int rc, sh;
        run_op("round_carry_ovf", 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, rc, sh);
        n_checks++;
        if (rc !== 9) begin
            n_fail++;
            $display("FAIL round_carry_latency: ready cycle %0d, required 9", rc);
        end
        run_op("round_unf", 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, rc, sh);
        n_checks++;
        if (rc !== 10 || sh !== 2) begin
            n_fail++;
            $display("FAIL round_unf_latency: ready cycle %0d shifts %0d, required 10 and 2",
                     rc, sh);
        end
    endtask

    task automatic test_reset_mid_norm();
        int rc, sh;
        bus.zero_flag_in = 1'b0;
        bus.norm_done_in = 1'b0;
        bus.beg_op       = 1'b1;
        @(posedge clk);
        #1;
        bus.beg_op = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        n_checks++;
        if (bus.shift_norm !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_norm_shift: shift_norm %b, required 1", bus.shift_norm);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_vec() !== 13'b0) begin
            n_fail++;
            $display("FAIL mid_norm_reset_immediate: outputs %b, required 0", dut_vec());
        end
        @(negedge clk);
        n_checks++;
        if (dut_vec() !== 13'b0) begin
            n_fail++;
            $display("FAIL mid_norm_reset_held: outputs %b, required 0", dut_vec());
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op("after_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, rc, sh);
        n_checks++;
        if (rc !== 8) begin
            n_fail++;
            $display("FAIL after_reset_latency: ready cycle %0d, required 8", rc);
        end
    endtask

    task automatic test_hold_ack();
        int rc, sh;
        run_op("hold_ack", 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10, rc, sh);
        n_checks++;
        if (rc !== 9 || sh !== 1) begin
            n_fail++;
            $display("FAIL hold_ack_latency: ready cycle %0d shifts %0d, required 9 and 1", rc, sh);
        end
    endtask

    task automatic test_back_to_back();
        bus.zero_flag_in = 1'b1;
        bus.norm_done_in = 1'b0;
        bus.beg_op       = 1'b1;
        @(posedge clk);
        #1;
        bus.beg_op = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Cycle 4: DONE; ack together with a new begin.
        bus.ack_op = 1'b1;
        bus.beg_op = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.ready !== 1'b1 || bus.zero_res !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done: ready %b zero_res %b, required 1 1", bus.ready, bus.zero_res);
        end
        @(posedge clk);
        #1;
        bus.ack_op = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.ready !== 1'b0 || bus.load_opnd !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: busy %b ready %b load_opnd %b, required 0 0 0",
                     bus.busy, bus.ready, bus.load_opnd);
        end
        @(posedge clk);
        #1;
        bus.beg_op = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.load_opnd !== 1'b1 || bus.busy !== 1'b1 || bus.zero_res !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_restart: load_opnd %b busy %b zero_res %b, required 1 1 0",
                     bus.load_opnd, bus.busy, bus.zero_res);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.ready !== 1'b1 || bus.zero_res !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_done: ready %b zero_res %b, required 1 1",
                     bus.ready, bus.zero_res);
        end
        bus.ack_op = 1'b1;
        @(posedge clk);
        #1;
        bus.ack_op       = 1'b0;
        bus.zero_flag_in = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.ready !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_final_idle: ready %b busy %b, required 0 0", bus.ready, bus.busy);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_normal_add();
        test_cancel();
        test_zero_shortcut();
        test_norm_limit();
        test_round_carry();
        test_reset_mid_norm();
        test_hold_ack();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound in case the DUT never returns to IDLE.
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fpu_add_subt_sequencer.md
# fpu_add_subt_sequencer

Control FSM for the floating-point add/subtract datapath. It sequences the datapath stages: operand load, effective-operation/result-sign capture, exponent compare, mantissa alignment, add/subtract, normalization, rounding and result hand-off. It issues one-cycle load/shift strobes to the datapath registers and exposes a begin/ready/acknowledge handshake to the requesting unit. The block holds no datapath arithmetic itself; it owns only the state register, the normalization shift counter and the latched exception flags.

## Interface
- SW, 23: mantissa width; normalization limit NORM_MAX = SW+2.
- CW, 5: normalization counter width; must satisfy 2^CW > SW+2.

- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- beg_op  input  1  start request; sampled only in IDLE.
- ack_op  input  1  result consumed; sampled only in DONE.
- zero_flag_in  input  1  datapath: |A|==|B| with effective subtraction, valid in EXP.
- norm_done_in  input  1  datapath: leading one in hidden-bit position, valid in NORM.
- round_ovf_in  input  1  datapath: rounding carried out of mantissa, valid in ROUND.
- overflow_in  input  1  datapath: exponent overflow, valid in ROUND.
- underflow_in  input  1  datapath: exponent underflow, valid in ROUND.
- load_opnd  output  1  load operand registers.
- load_sign  output  1  capture effective operation and result sign.
- load_exp  output  1  load exponent difference / swap registers.
- shift_align  output  1  align the smaller mantissa.
- load_add  output  1  load adder result.
- shift_norm  output  1  left-shift mantissa by 1, decrement exponent.
- load_round  output  1  load rounded mantissa.
- shift_adj  output  1  right-shift mantissa by 1, increment exponent, after round carry-out.
- busy  output  1  high in every state except IDLE and DONE.
- ready  output  1  result valid; high only in DONE.
- zero_res  output  1  result forced to +0; valid while ready.
- ovf_flag  output  1  latched overflow; valid while ready.
- unf_flag  output  1  latched underflow; valid while ready.

## Operation
- States: IDLE, LOAD, SIGN, EXP, ALIGN, ADD, NORM, ROUND, ADJ, DONE.
- IDLE -> LOAD when beg_op=1. Otherwise stay in IDLE.
- LOAD -> SIGN -> EXP: unconditional.
- EXP -> DONE with zero_res set when zero_flag_in=1. Otherwise EXP -> ALIGN.
- ALIGN -> ADD -> NORM: unconditional. Entering NORM clears the counter to 0.
- NORM, norm_done_in=1 -> ROUND, with shift_norm=0.
- NORM, norm_done_in=0 and count<NORM_MAX -> stay in NORM; shift_norm=1 and count increments.
- NORM, norm_done_in=0 and count==NORM_MAX -> DONE with zero_res set.
- ROUND: ovf_flag and unf_flag capture overflow_in and underflow_in. round_ovf_in=1 -> ADJ; otherwise -> DONE.
- ADJ -> DONE: unconditional.
- DONE -> IDLE when ack_op=1.
- Strobes are decoded from the state register. Each is high exactly one cycle per visit to its state: load_opnd/LOAD, load_sign/SIGN, load_exp/EXP, shift_align/ALIGN, load_add/ADD, load_round/ROUND, shift_adj/ADJ.
- shift_norm is the only strobe that also depends on an input: shift_norm = (state==NORM) & ~norm_done_in & (count<NORM_MAX).
- zero_res, ovf_flag and unf_flag are registered. They are cleared on LOAD entry and hold through DONE.
- beg_op outside IDLE is ignored; ack_op outside DONE is ignored.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, count=0. Every output is 0, including busy, ready and flags. Reset mid-operation aborts immediately; no strobe is issued after rst falls.
- Latency: with beg_op sampled high at edge k, LOAD occupies cycle k+1.
- Minimum path (norm_done_in=1 on first NORM cycle, no round carry): ready first high in cycle k+8.
- Each normalization shift adds 1 cycle; ADJ adds 1 cycle.
- Zero shortcut from EXP: ready in cycle k+4.
- ready holds until the edge at which ack_op=1 is sampled; IDLE follows in the next cycle.
- beg_op=1 together with that ack_op is not accepted. A new operation needs beg_op sampled in IDLE, so the earliest back-to-back restart is LOAD two cycles after the acking edge.
- Counter saturates at NORM_MAX; it never wraps.

## Test plan
- Normal add, norm_done_in=1 immediately, round_ovf_in=0, beg_op pulsed at edge 0 -> one-cycle strobes in order load_opnd, load_sign, load_exp, shift_align, load_add, load_round in cycles 1-7; ready=1 from cycle 8; zero_res=ovf_flag=unf_flag=0.
- Subtraction with cancellation, norm_done_in low for 5 NORM cycles -> shift_norm high exactly 5 cycles; ready at cycle 13.
- zero_flag_in=1 in EXP -> no shift_align/load_add; ready=1 and zero_res=1 at cycle 4.
- norm_done_in held 0 -> shift_norm high 25 cycles (SW=23); DONE with zero_res=1.
- round_ovf_in=1 and overflow_in=1 in ROUND -> shift_adj one cycle; ready with ovf_flag=1, one cycle later than the no-carry case.
- rst pulsed low during NORM -> all outputs 0 immediately; new beg_op runs a full clean sequence.
- ack_op held low 10 cycles in DONE -> ready and flags stable; beg_op during busy ignored.
